// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU control path.
//
// Contents:
//   ctrl_state_e   - control FSM state encoding
//   instr_class_e  - decoded instruction class used by the DECODE transition
//   OPC_* / FN_*   - opcode and R-type funct constants
//   ALU_*          - ALU operation codes
//   PC_SRC_*       - pc_src mux encodings
//   SRCB_*         - alu_src_b mux encodings
//   classify()     - opcode/funct -> instruction class
//   uses_sext()    - opcodes whose immediate is sign extended
//
// StTrap is only reachable when CTRL_ILLEGAL_TRAP_EN is defined.
package cpu_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StDecode,
        StExecR,
        StExecI,
        StMemAddr,
        StMemRd,
        StMemWb,
        StMemWr,
        StBranch,
        StJump,
        StWbR,
        StWbI,
        StTrap
    } ctrl_state_e;

    typedef enum logic [2:0] {
        ClsRtype,
        ClsItype,
        ClsMem,
        ClsBranch,
        ClsJump,
        ClsIllegal
    } instr_class_e;

    // Opcodes (instruction[31:26])
    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_ADDIU = 6'h09;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_LUI   = 6'h0F;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    // R-type funct (instruction[5:0])
    localparam logic [5:0] FN_ADD = 6'h21;
    localparam logic [5:0] FN_SUB = 6'h23;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;
    localparam logic [2:0] ALU_LUI = 3'd5;

    // pc_src encodings
    localparam logic [1:0] PC_SRC_SEQ = 2'd0;
    localparam logic [1:0] PC_SRC_BR  = 2'd1;
    localparam logic [1:0] PC_SRC_JMP = 2'd2;

    // alu_src_b encodings
    localparam logic [1:0] SRCB_RT      = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    function automatic instr_class_e classify(input logic [5:0] op, input logic [5:0] fn);
        instr_class_e cls;
        cls = ClsIllegal;
        case (op)
            OPC_RTYPE: begin
                if ((fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
                    (fn == FN_OR) || (fn == FN_SLT)) begin
                    cls = ClsRtype;
                end
            end
            OPC_ADDIU, OPC_ANDI, OPC_ORI, OPC_LUI: cls = ClsItype;
            OPC_LW, OPC_SW:                        cls = ClsMem;
            OPC_BEQ:                               cls = ClsBranch;
            OPC_J:                                 cls = ClsJump;
            default:                               cls = ClsIllegal;
        endcase
        return cls;
    endfunction

    function automatic logic uses_sext(input logic [5:0] op);
        return (op == OPC_ADDIU) || (op == OPC_LW) || (op == OPC_SW) || (op == OPC_BEQ);
    endfunction

endpackage

// File: rtl/alu_decode.sv
// ALU operation decode for the multi-cycle controller.
//
// Ports:
//   i_state   - current control FSM state
//   i_opcode  - latched opcode
//   i_funct   - latched funct
//   o_alu_op  - ALU operation code
//
// FETCH/DECODE/address states add; BRANCH subtracts for the zero compare; R-type and
// I-type ALU states take their operation from funct/opcode. Writeback states keep the
// execute operation so the ALU result stays stable while it is written.
module alu_decode
    import cpu_pkg::*;
#(
    parameter int unsigned OP_W    = 6,
    parameter int unsigned ALUOP_W = 3
) (
    input  ctrl_state_e        i_state,
    input  logic [OP_W-1:0]    i_opcode,
    input  logic [OP_W-1:0]    i_funct,
    output logic [ALUOP_W-1:0] o_alu_op
);

    always_comb begin
        o_alu_op = ALUOP_W'(ALU_ADD);
        case (i_state)
            StExecR, StWbR: begin
                case (i_funct)
                    FN_ADD:  o_alu_op = ALUOP_W'(ALU_ADD);
                    FN_SUB:  o_alu_op = ALUOP_W'(ALU_SUB);
                    FN_AND:  o_alu_op = ALUOP_W'(ALU_AND);
                    FN_OR:   o_alu_op = ALUOP_W'(ALU_OR);
                    FN_SLT:  o_alu_op = ALUOP_W'(ALU_SLT);
                    default: o_alu_op = ALUOP_W'(ALU_ADD);
                endcase
            end
            StExecI, StWbI: begin
                case (i_opcode)
                    OPC_ADDIU: o_alu_op = ALUOP_W'(ALU_ADD);
                    OPC_ANDI:  o_alu_op = ALUOP_W'(ALU_AND);
                    OPC_ORI:   o_alu_op = ALUOP_W'(ALU_OR);
                    OPC_LUI:   o_alu_op = ALUOP_W'(ALU_LUI);
                    default:   o_alu_op = ALUOP_W'(ALU_ADD);
                endcase
            end
            StBranch: o_alu_op = ALUOP_W'(ALU_SUB);
            default:  o_alu_op = ALUOP_W'(ALU_ADD);
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU control unit (Moore FSM).
//
// Sequences PC, IR, register file, ALU, immediate extender and memory over several
// cycles per instruction and stalls FETCH/MEM_RD/MEM_WR on mem_ready. All outputs are
// combinational decode of the registered state, latched opcode/funct, zero and
// mem_ready.
//
// Ports:
//   clk, rst_n        - clock (rising edge), asynchronous active-low reset
//   opcode, funct     - instruction fields from the IR (sampled in DECODE)
//   zero              - ALU zero flag
//   mem_ready         - memory completes the current access this cycle
//   pc_we, pc_src     - PC write enable / source (PC+4, branch, jump)
//   ir_we             - instruction register load
//   mem_re, mem_we    - memory read / write
//   iord              - memory address select (0 = PC, 1 = ALU result)
//   reg_we, reg_dst   - register write enable / destination (0 = rt, 1 = rd)
//   mem_to_reg        - writeback source (0 = ALU, 1 = memory)
//   sext              - immediate sign extend (1) or zero extend (0)
//   alu_src_b, alu_op - ALU operand B select / operation
//   retire            - one-cycle pulse when an instruction completes
//   illegal           - illegal-instruction trap flag
//
// Build option CTRL_ILLEGAL_TRAP_EN: when defined, an illegal opcode/funct enters TRAP,
// which holds with illegal=1 until reset. When undefined, an illegal instruction
// retires as a NOP from DECODE and illegal is tied low.
module multicycle_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned OP_W    = 6,
    parameter int unsigned ALUOP_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OP_W-1:0]    opcode,
    input  logic [OP_W-1:0]    funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_we,
    output logic [1:0]         pc_src,
    output logic               ir_we,
    output logic               mem_re,
    output logic               mem_we,
    output logic               iord,
    output logic               reg_we,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               sext,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               retire,
    output logic               illegal
);

    ctrl_state_e        r_state;
    ctrl_state_e        w_state_next;
    logic [OP_W-1:0]    r_op;
    logic [OP_W-1:0]    r_funct;
    instr_class_e       w_dec_class;
    logic               w_sext_op;
    logic [ALUOP_W-1:0] w_alu_op;

    // DECODE steers on the live IR fields; later states use the latched copies.
    assign w_dec_class = classify(opcode, funct);
    assign w_sext_op   = uses_sext(r_op);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Opcode/funct latch, captured at the end of DECODE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= '0;
            r_funct <= '0;
        end else if (r_state == StDecode) begin
            r_op    <= opcode;
            r_funct <= funct;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  w_state_next = StFetch;
            StFetch: if (mem_ready) w_state_next = StDecode;
            StDecode: begin
                case (w_dec_class)
                    ClsRtype:  w_state_next = StExecR;
                    ClsItype:  w_state_next = StExecI;
                    ClsMem:    w_state_next = StMemAddr;
                    ClsBranch: w_state_next = StBranch;
                    ClsJump:   w_state_next = StJump;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default:   w_state_next = StTrap;
`else
                    default:   w_state_next = StFetch;
`endif
                endcase
            end
            StExecR:   w_state_next = StWbR;
            StExecI:   w_state_next = StWbI;
            StMemAddr: w_state_next = (r_op == OPC_LW) ? StMemRd : StMemWr;
            StMemRd:   if (mem_ready) w_state_next = StMemWb;
            StMemWr:   if (mem_ready) w_state_next = StFetch;
            StMemWb, StWbR, StWbI, StBranch, StJump: w_state_next = StFetch;
`ifdef CTRL_ILLEGAL_TRAP_EN
            StTrap:    w_state_next = StTrap;
`endif
            default:   w_state_next = StIdle;
        endcase
    end

    alu_decode #(
        .OP_W    (OP_W),
        .ALUOP_W (ALUOP_W)
    ) u_alu_decode (
        .i_state  (r_state),
        .i_opcode (r_op),
        .i_funct  (r_funct),
        .o_alu_op (w_alu_op)
    );

    assign alu_op = w_alu_op;

    // Output decode
    always_comb begin
        pc_we      = 1'b0;
        pc_src     = PC_SRC_SEQ;
        ir_we      = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        sext       = 1'b0;
        alu_src_b  = SRCB_RT;
        retire     = 1'b0;
        illegal    = 1'b0;
        unique case (r_state)
            StFetch: begin
                mem_re    = 1'b1;
                alu_src_b = SRCB_FOUR;
                // IR and PC commit only once the instruction word is actually there
                ir_we     = mem_ready;
                pc_we     = mem_ready;
            end
            StDecode: begin
                // Precompute branch target while the register file is read
                alu_src_b = SRCB_IMM_SH2;
                sext      = 1'b1;
`ifndef CTRL_ILLEGAL_TRAP_EN
                retire    = (w_dec_class == ClsIllegal);
`endif
            end
            StWbR: begin
                reg_we  = 1'b1;
                reg_dst = 1'b1;
                retire  = 1'b1;
            end
            StExecI: begin
                alu_src_b = SRCB_IMM;
                sext      = w_sext_op;
            end
            StWbI: begin
                alu_src_b = SRCB_IMM;
                sext      = w_sext_op;
                reg_we    = 1'b1;
                retire    = 1'b1;
            end
            StMemAddr: begin
                alu_src_b = SRCB_IMM;
                sext      = w_sext_op;
            end
            StMemRd: begin
                alu_src_b = SRCB_IMM;
                sext      = w_sext_op;
                mem_re    = 1'b1;
                iord      = 1'b1;
            end
            StMemWb: begin
                sext       = w_sext_op;
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
            end
            StMemWr: begin
                alu_src_b = SRCB_IMM;
                sext      = w_sext_op;
                mem_we    = 1'b1;
                iord      = 1'b1;
                retire    = mem_ready;
            end
            StBranch: begin
                sext   = w_sext_op;
                pc_we  = zero;
                pc_src = PC_SRC_BR;
                retire = 1'b1;
            end
            StJump: begin
                pc_we  = 1'b1;
                pc_src = PC_SRC_JMP;
                retire = 1'b1;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            StTrap: illegal = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control unit for the CPU datapath: a Moore state machine that sequences the PC, instruction register, register file, ALU, immediate extender and data memory over several cycles per instruction. It decodes opcode/funct, drives every datapath enable and mux select (including the extender's `sext`), and stalls on a memory ready handshake. It replaces the single-cycle combinational decoder and sits between the instruction register and all datapath write enables.

## Interface
Parameters:
- `OP_W`, 6, opcode and funct width
- `ALUOP_W`, 3, ALU operation code width

Ports:
- `clk`  input  1  system clock, rising edge
- `rst_n`  input  1  asynchronous, active-low reset
- `opcode`  input  6  instruction[31:26] from the instruction register
- `funct`  input  6  instruction[5:0]
- `zero`  input  1  ALU zero flag
- `mem_ready`  input  1  memory completes the current access this cycle
- `pc_we`  output  1  PC write enable
- `pc_src`  output  2  0 = PC+4, 1 = branch target, 2 = jump target
- `ir_we`  output  1  instruction register load
- `mem_re` / `mem_we`  output  1 each  data/instruction memory read / write
- `iord`  output  1  memory address select: 0 = PC, 1 = ALU result
- `reg_we`  output  1  register file write enable
- `reg_dst`  output  1  0 = rt, 1 = rd
- `mem_to_reg`  output  1  0 = ALU result, 1 = memory data
- `sext`  output  1  immediate extender: 1 = sign, 0 = zero extend
- `alu_src_b`  output  2  0 = rt, 1 = constant 4, 2 = extended immediate, 3 = extended immediate << 2
- `alu_op`  output  3  ALU operation
- `retire`  output  1  one-cycle pulse when an instruction completes
- `illegal`  output  1  illegal-opcode trap flag (macro-dependent)

## Operation
- States: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, WB_R, WB_I, TRAP.
- Opcode and funct are latched in DECODE; later states use the latched copies.
- Transitions: IDLE→FETCH; FETCH→DECODE when `mem_ready`, else hold. DECODE → EXEC_R (op 0x00), EXEC_I (addiu 0x09, andi 0x0C, ori 0x0D, lui 0x0F), MEM_ADDR (lw 0x23, sw 0x2B), BRANCH (beq 0x04), JUMP (j 0x02), else illegal path. EXEC_R→WB_R; EXEC_I→WB_I; MEM_ADDR→MEM_RD (lw) or MEM_WR (sw); MEM_RD→MEM_WB when `mem_ready`; MEM_WR→FETCH when `mem_ready`; WB_R, WB_I, MEM_WB, BRANCH, JUMP→FETCH.
- FETCH: `mem_re`=1, `iord`=0, `alu_src_b`=1, `alu_op`=ADD; `ir_we` and `pc_we` (`pc_src`=0) only in the cycle `mem_ready`=1.
- DECODE: `alu_src_b`=3, `sext`=1, `alu_op`=ADD (precompute branch target).
- `sext`=1 for addiu, lw, sw, beq; 0 for andi, ori, lui and all other states.
- R-type funct: 0x21 ADD, 0x23 SUB, 0x24 AND, 0x25 OR, 0x2A SLT; any other funct is illegal.
- BRANCH: `alu_op`=SUB; `pc_we`=`zero`, `pc_src`=1. JUMP: `pc_we`=1, `pc_src`=2.
- `retire` pulses in WB_R, WB_I, MEM_WB, BRANCH, JUMP, and in MEM_WR with `mem_ready`.

## Timing
- Outputs are combinational decode of the registered state, latched opcode/funct, `zero` and `mem_ready`; no output is registered.
- Reset (asserted or mid-instruction): state=IDLE immediately; all outputs 0; partially executed instruction is abandoned and has no effect.
- CPI with `mem_ready` always 1: R-type 4, I-type ALU 4, lw 5, sw 4, beq 3, j 3. Each cycle of `mem_ready`=0 adds one cycle in FETCH, MEM_RD or MEM_WR.
- Never two write enables to the same resource in one cycle; `mem_we` and `mem_re` mutually exclusive.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined: illegal opcode/funct goes DECODE→TRAP; TRAP holds indefinitely with `illegal`=1, all enables 0, until `rst_n` is asserted.
- Not defined: illegal opcode/funct goes DECODE→FETCH as a NOP with `retire` pulsed in DECODE; `illegal` tied 0; TRAP state not built.

## Structure
- Shared package `cpu_pkg`: state enumeration, opcode and funct constants, ALU operation codes (ADD=0, SUB=1, AND=2, OR=3, SLT=4, LUI=5), `pc_src`/`alu_src_b` encodings.
- One sub-module `alu_decode`: combinational map from (state, opcode, funct) to `alu_op`.

## Test plan
- Reset release, `mem_ready`=1, opcode 0x00 funct 0x21 → IDLE,FETCH,DECODE,EXEC_R,WB_R; `reg_we`=1,`reg_dst`=1 in WB_R; `retire` at cycle 5.
- addiu (0x09) then ori (0x0D) → `sext`=1 in EXEC_I/WB_I for addiu, `sext`=0 for ori, `alu_src_b`=2 both.
- lw with `mem_ready` low 3 cycles in MEM_RD → MEM_RD held 4 cycles, then MEM_WB with `mem_to_reg`=1, total 8 cycles.
- beq with `zero`=1 then `zero`=0 → `pc_we`=1,`pc_src`=1 in first BRANCH; `pc_we`=0 in second; 3 cycles each.
- Opcode 0x3F → with macro: TRAP, `illegal`=1 held 20 cycles; without: back to FETCH, `illegal`=0.
- `rst_n` pulsed low during MEM_WR → `mem_we` drops same cycle, state IDLE, no `retire`.
